// File: rtl/knn_pkg.sv
// knn_pkg: definitions shared by the kNN vote stage and the neighbour list.
// FSM state encoding, the position of the label inside knn_info, and the
// read latency of the list's get/id port.
package knn_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_DRAIN = 3'd2,
    S_SCAN  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam int INFO_W    = 8;  // width of one neighbour entry
  localparam int ID_W      = 4;  // rank address width
  localparam int LABEL_LSB = 0;  // label sits in the low bits of knn_info
  localparam int INFO_LAT  = 1;  // knn_info is valid this many cycles after knn_get

endpackage

// File: rtl/knn_vote_hist.sv
// knn_vote_hist: per-class vote counters for the kNN vote stage.
// Saturating increment, synchronous clear, and an indexed read port used by
// the argmax scan. Optional macro KNN_VOTE_NEAREST_TIE_EN adds per-class
// first_rank storage (lowest rank that voted for the class).
module knn_vote_hist
  import knn_pkg::*;
#(
  parameter int NBR_KNN   = 4,
  parameter int NBR_CLASS = 8,
  parameter int LABEL_W   = 4,
  parameter int CNT_W     = $clog2(NBR_KNN + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               inc_en,
  input  logic [LABEL_W-1:0] inc_idx,
`ifdef KNN_VOTE_NEAREST_TIE_EN
  input  logic [ID_W-1:0]    inc_rank,
  output logic [ID_W-1:0]    rd_first,
`endif
  input  logic [LABEL_W-1:0] rd_idx,
  output logic [CNT_W-1:0]   rd_cnt
);

  logic [CNT_W-1:0] cnt [NBR_CLASS];

  // Vote counters: cleared on reset or new run, saturate at NBR_KNN.
  always_ff @(posedge clk) begin
    for (int c = 0; c < NBR_CLASS; c++) begin
      if (rst || clr) begin
        cnt[c] <= '0;
      end else if (inc_en && (inc_idx == LABEL_W'(c)) &&
                   (cnt[c] != CNT_W'(NBR_KNN))) begin
        cnt[c] <= cnt[c] + 1'b1;
      end
    end
  end

  assign rd_cnt = cnt[rd_idx];

`ifdef KNN_VOTE_NEAREST_TIE_EN
  logic [ID_W-1:0] first [NBR_CLASS];

  // First-voter rank per class: all ones means no vote yet.
  always_ff @(posedge clk) begin
    for (int c = 0; c < NBR_CLASS; c++) begin
      if (rst || clr) begin
        first[c] <= '1;
      end else if (inc_en && (inc_idx == LABEL_W'(c)) && (inc_rank < first[c])) begin
        first[c] <= inc_rank;
      end
    end
  end

  assign rd_first = first[rd_idx];
`endif

endmodule

// File: rtl/knn_vote.sv
// knn_vote: majority vote over the NBR_KNN nearest neighbours of a test point.
// Reads ranks 0..NBR_KNN-1 from the neighbour list, tallies labels, then scans
// the histogram for the most-voted class (ties -> lowest class index).
// Optional macro KNN_VOTE_NEAREST_TIE_EN: ties go to the class whose first
// vote came from the nearer neighbour.
//
// state   | meaning
// --------+-----------------------------------------------
// IDLE    | waiting for start
// FETCH   | issuing knn_get for ranks 0..NBR_KNN-1
// DRAIN   | last read entry arrives and is tallied
// SCAN    | argmax over classes, one class per cycle
// DONE    | result registered, done pulse
module knn_vote
  import knn_pkg::*;
#(
  parameter int NBR_KNN   = 4,
  parameter int NBR_CLASS = 8,
  parameter int LABEL_W   = 4,
  parameter int CNT_W     = $clog2(NBR_KNN + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               knn_get,
  output logic [ID_W-1:0]    knn_id,
  input  logic [INFO_W-1:0]  knn_info,
  output logic               busy,
  output logic               done,
  output logic [LABEL_W-1:0] label,
  output logic [CNT_W-1:0]   votes,
  output logic               err
);

  state_t             state;
  logic               get_d;
  logic [LABEL_W-1:0] cap_lbl;
  logic               cap_ok;
  logic               err_acc;
  logic               hist_clr;
  logic [LABEL_W-1:0] scan_idx;
  logic [LABEL_W-1:0] best_lbl;
  logic [CNT_W-1:0]   best_cnt;
  logic [CNT_W-1:0]   rd_cnt;
  logic               take;
  logic               info_unused;

  assign cap_lbl     = knn_info[LABEL_LSB +: LABEL_W];
  assign cap_ok      = ({1'b0, cap_lbl} < (LABEL_W + 1)'(NBR_CLASS));
  assign hist_clr    = (state == S_IDLE) && start;
  assign info_unused = ^knn_info;

  // knn_info qualifier: list data follows knn_get by one cycle.
  always_ff @(posedge clk) begin
    if (rst) get_d <= 1'b0;
    else     get_d <= knn_get;
  end

`ifdef KNN_VOTE_NEAREST_TIE_EN
  logic [ID_W-1:0] cap_rank;
  logic [ID_W-1:0] rd_first;
  logic [ID_W-1:0] best_first;

  // Rank of the entry currently on knn_info.
  always_ff @(posedge clk) begin
    if (rst) cap_rank <= '0;
    else     cap_rank <= knn_id;
  end

  assign take = (rd_cnt > best_cnt) ||
                ((rd_cnt == best_cnt) && (rd_first < best_first));
`else
  assign take = (rd_cnt > best_cnt);
`endif

  knn_vote_hist #(
    .NBR_KNN   (NBR_KNN),
    .NBR_CLASS (NBR_CLASS),
    .LABEL_W   (LABEL_W),
    .CNT_W     (CNT_W)
  ) u_hist (
    .clk      (clk),
    .rst      (rst),
    .clr      (hist_clr),
    .inc_en   (get_d && cap_ok),
    .inc_idx  (cap_lbl),
`ifdef KNN_VOTE_NEAREST_TIE_EN
    .inc_rank (cap_rank),
    .rd_first (rd_first),
`endif
    .rd_idx   (scan_idx),
    .rd_cnt   (rd_cnt)
  );

  // Sequencing FSM with registered outputs, rank counter and argmax.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      knn_get  <= 1'b0;
      knn_id   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      label    <= '0;
      votes    <= '0;
      err      <= 1'b0;
      err_acc  <= 1'b0;
      scan_idx <= '0;
      best_lbl <= '0;
      best_cnt <= '0;
`ifdef KNN_VOTE_NEAREST_TIE_EN
      best_first <= '1;
`endif
    end else begin
      if (get_d && !cap_ok) err_acc <= 1'b1;
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            state   <= S_FETCH;
            knn_get <= 1'b1;
            knn_id  <= '0;
            busy    <= 1'b1;
            err_acc <= 1'b0;
          end
        end
        S_FETCH: begin
          if (knn_id == ID_W'(NBR_KNN - 1)) begin
            knn_get <= 1'b0;
            state   <= S_DRAIN;
          end else begin
            knn_id <= knn_id + 1'b1;
          end
        end
        S_DRAIN: begin
          knn_id   <= '0;
          scan_idx <= '0;
          best_lbl <= '0;
          best_cnt <= '0;
`ifdef KNN_VOTE_NEAREST_TIE_EN
          best_first <= '1;
`endif
          state <= S_SCAN;
        end
        S_SCAN: begin
          if (take) begin
            best_cnt <= rd_cnt;
            best_lbl <= scan_idx;
`ifdef KNN_VOTE_NEAREST_TIE_EN
            best_first <= rd_first;
`endif
          end
          if (scan_idx == LABEL_W'(NBR_CLASS - 1)) begin
            label <= take ? scan_idx : best_lbl;
            votes <= take ? rd_cnt : best_cnt;
            err   <= err_acc;
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            scan_idx <= scan_idx + 1'b1;
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_knn_vote.sv
// tb_knn_vote: scoreboard bench for knn_vote with a behavioural neighbour list.
module tb_knn_vote;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       knn_get;
  logic [3:0] knn_id;
  logic [7:0] knn_info = 8'h00;
  logic       busy;
  logic       done;
  logic [3:0] label;
  logic [2:0] votes;
  logic       err;

  always #5 clk = ~clk;

  knn_vote dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .knn_get  (knn_get),
    .knn_id   (knn_id),
    .knn_info (knn_info),
    .busy     (busy),
    .done     (done),
    .label    (label),
    .votes    (votes),
    .err      (err)
  );

  // Neighbour list: label in low nibble, junk in high nibble; junk when idle.
  logic [3:0] mem [4];
  always @(posedge clk) begin
    if (knn_get) knn_info <= {4'hA, mem[knn_id[1:0]]};
    else         knn_info <= 8'h5F;
  end

  typedef struct {
    logic [3:0] lbl;
    logic [2:0] vts;
    logic       e;
    int         due;
    string      name;
  } exp_t;

  exp_t       sb[$];
  exp_t       cur;
  int         n_chk = 0;
  int         n_fail = 0;
  int         negcnt = 0;
  int         done_cnt = 0;
  logic [3:0] id_log[$];

  task automatic check(input string nm, input int act, input int req);
    n_chk++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", nm, act, req);
    end
  endtask

  // Monitor: pops the scoreboard on every done pulse.
  always @(negedge clk) begin
    negcnt++;
    if (knn_get) id_log.push_back(knn_id);
    if (done) begin
      done_cnt++;
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_done: got done with label %0d, required no done", label);
      end else begin
        cur = sb.pop_front();
        check({cur.name, "_label"}, label, cur.lbl);
        check({cur.name, "_votes"}, votes, cur.vts);
        check({cur.name, "_err"}, err, cur.e);
        check({cur.name, "_latency"}, negcnt, cur.due);
      end
    end
  end

  task automatic load(input logic [3:0] a, b, c, d);
    mem[0] = a; mem[1] = b; mem[2] = c; mem[3] = d;
  endtask

  // Called at #1 after a posedge: start is high for the following cycle (cycle 0).
  task automatic push_exp(input logic [3:0] l, input logic [2:0] v, input logic e,
                          input string nm);
    exp_t x;
    x.lbl = l; x.vts = v; x.e = e; x.name = nm;
    x.due = negcnt + 1 + 14;
    sb.push_back(x);
  endtask

  task automatic wait_idle(input string nm);
    int i;
    i = 0;
    while ((sb.size() != 0 || busy) && i < 60) begin
      @(posedge clk);
      i++;
    end
    check({nm, "_pending_results"}, sb.size(), 0);
    sb.delete();
    @(posedge clk); #1;
  endtask

  task automatic run(input logic [3:0] a, b, c, d, input logic [3:0] l,
                     input logic [2:0] v, input logic e, input string nm);
    load(a, b, c, d);
    @(posedge clk); #1;
    push_exp(l, v, e, nm);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_idle(nm);
  endtask

  initial begin
    int d0;
    load(4'd0, 4'd0, 4'd0, 4'd0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_get", knn_get, 0);
    check("rst_id", knn_id, 0);
    check("rst_label", label, 0);
    check("rst_votes", votes, 0);
    check("rst_err", err, 0);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    // Basic vote with rank sequence check.
    id_log.delete();
    run(4'd2, 4'd5, 4'd2, 4'd7, 4'd2, 3'd2, 1'b0, "basic");
    check("id_count", id_log.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < id_log.size()) check($sformatf("id_seq%0d", i), id_log[i], i);
    end

    run(4'd3, 4'd3, 4'd3, 4'd3, 4'd3, 3'd4, 1'b0, "unanimous");
    run(4'd1, 4'd6, 4'd6, 4'd0, 4'd6, 3'd2, 1'b0, "second_run");

`ifdef KNN_VOTE_NEAREST_TIE_EN
    run(4'd5, 4'd1, 4'd1, 4'd5, 4'd5, 3'd2, 1'b0, "tie");
`else
    run(4'd5, 4'd1, 4'd1, 4'd5, 4'd1, 3'd2, 1'b0, "tie");
`endif

    run(4'd9, 4'd12, 4'd9, 4'd2, 4'd2, 3'd1, 1'b1, "some_invalid");
    run(4'd15, 4'd15, 4'd15, 4'd15, 4'd0, 3'd0, 1'b1, "all_invalid");
    run(4'd0, 4'd0, 4'd4, 4'd4, 4'd0, 3'd2, 1'b0, "clear_err");

    // start pulsed again in cycle 5 must be ignored.
    load(4'd4, 4'd4, 4'd1, 4'd0);
    d0 = done_cnt;
    @(posedge clk); #1;
    push_exp(4'd4, 3'd2, 1'b0, "restart_ignored");
    start = 1'b1;
    for (int c = 1; c <= 14; c++) begin
      @(posedge clk); #1;
      start = (c == 5);
      check($sformatf("busy_cycle%0d", c), busy, 1);
    end
    @(posedge clk); #1;
    check("busy_after_done", busy, 0);
    wait_idle("restart_ignored");
    repeat (20) @(posedge clk);
    #1;
    check("single_done", done_cnt, d0 + 1);

    // Reset in the third FETCH cycle aborts without a done pulse.
    load(4'd7, 4'd7, 4'd0, 4'd1);
    d0 = done_cnt;
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_get", knn_get, 0);
    repeat (20) @(posedge clk);
    #1;
    check("abort_no_done", done_cnt, d0);
    run(4'd7, 4'd7, 4'd0, 4'd1, 4'd7, 3'd2, 1'b0, "after_abort");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required test completion");
    $fatal(1, "watchdog");
  end

endmodule
